// File: rtl/serial_compare_arbiter.sv
// serial_compare_arbiter: two-requester round-robin front end sharing one MSB-first bit-serial unsigned comparator
module serial_compare_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
    output logic             busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             id_q, lt_q, eq_q, gt_q, last_grant;
    logic             grant, accept, a_bit, b_bit;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept = (state == IDLE) && (grant ? req1_valid : req0_valid);
        a_bit  = a_q[idx];
        b_bit  = b_q[idx];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: RUN always spans WIDTH cycles, DONE waits for the consumer
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (idx == '0) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on accept, then one bit per RUN cycle; the first differing bit decides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            id_q       <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            a_q        <= grant ? req1_a : req0_a;
            b_q        <= grant ? req1_b : req0_b;
            idx        <= IW'(WIDTH - 1);
            id_q       <= grant;
            lt_q       <= 1'b0;
            eq_q       <= 1'b1;
            gt_q       <= 1'b0;
            last_grant <= grant;
        end else if (state == RUN) begin
            if (eq_q && (a_bit != b_bit)) begin
                eq_q <= 1'b0;
                gt_q <= a_bit;
                lt_q <= b_bit;
            end
            idx <= idx - IW'(1);
        end
    end

    // Outputs: ready only in IDLE for the granted, valid requester; result fields gated to zero outside DONE
    always_comb begin
        req0_ready = (state == IDLE) && !grant && req0_valid;
        req1_ready = (state == IDLE) && grant && req1_valid;
        res_valid  = (state == DONE);
        res_id     = res_valid & id_q;
        res_lt     = res_valid & lt_q;
        res_eq     = res_valid & eq_q;
        res_gt     = res_valid & gt_q;
        busy       = (state != IDLE);
    end
endmodule

// File: tb/tb_serial_compare_arbiter.sv
// tb_serial_compare_arbiter: directed and randomized checks of the shared serial comparator against a behavioural model
module tb_serial_compare_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0, res_ready = 0;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic req0_ready, req1_ready, res_valid, res_id, res_lt, res_eq, res_gt, busy;

    logic n_req0_valid = 0, n_res_ready = 0;
    logic [3:0] n_req0_a = 0, n_req0_b = 0;
    logic n_req0_ready, n_req1_ready, n_res_valid, n_res_id, n_res_lt, n_res_eq, n_res_gt, n_busy;

    int vectors = 0;
    int miscompares = 0;
    logic last_g = 1'b1;

    always #5 clk = ~clk;

    serial_compare_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .busy(busy)
    );

    serial_compare_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_a(n_req0_a), .req0_b(n_req0_b),
        .req1_valid(1'b0), .req1_ready(n_req1_ready), .req1_a(4'h0), .req1_b(4'h0),
        .res_valid(n_res_valid), .res_ready(n_res_ready), .res_id(n_res_id),
        .res_lt(n_res_lt), .res_eq(n_res_eq), .res_gt(n_res_gt), .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: model picks the winner and the verdict from plain arithmetic
    task automatic serve(input logic v0, input logic v1, input logic [W-1:0] a0, b0, a1, b1, input int hold);
        int g, n;
        logic [W-1:0] ea, eb;
        logic [2:0] exp_f;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready = 1'b0;
        g = (v0 && v1) ? (last_g ? 0 : 1) : (v1 ? 1 : 0);
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        exp_f = (ea < eb) ? 3'b100 : (ea == eb) ? 3'b010 : 3'b001;
        #1;
        chk("req0_ready", req0_ready, v0 && g == 0);
        chk("req1_ready", req1_ready, v1 && g == 1);
        @(posedge clk);
        last_g = g[0];
        #1;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        n = 0;
        while (n < 3 * W) begin
            if (res_valid) break;
            chk("run_outputs", {busy, req0_ready, req1_ready, res_id, res_lt, res_eq, res_gt}, 7'b1000000);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, W);
        chk("res_id", res_id, g);
        chk("res_flags", {res_lt, res_eq, res_gt}, exp_f);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_res", {res_valid, res_id, res_lt, res_eq, res_gt}, {1'b1, g[0], exp_f});
            chk("hold_ctl", {busy, req0_ready, req1_ready}, 3'b100);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("release", {res_valid, busy, res_id, res_lt, res_eq, res_gt}, 6'b0);
    endtask

    initial begin
        int n;
        logic v0, v1;
        #2;
        chk("reset_outputs", {req0_ready, req1_ready, res_valid, res_id, res_lt, res_eq, res_gt, busy}, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // Tie at the first edge after reset goes to req0, then req1, then req0 again
        serve(1, 1, 8'h00, 8'hFF, 8'h01, 8'h00, 0);
        serve(1, 1, 8'h00, 8'hFF, 8'h01, 8'h00, 0);
        serve(1, 1, 8'h33, 8'h44, 8'h01, 8'h00, 0);
        serve(1, 0, 8'h5A, 8'h5A, 8'h00, 8'h00, 0);
        serve(0, 1, 8'h00, 8'h00, 8'h80, 8'h7F, 0);
        // Stalled consumer with both requesters waiting
        serve(1, 1, 8'hC3, 8'hC3, 8'h10, 8'h20, 5);
        // Asynchronous reset while the fourth bit is being processed
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'hF0;
        #1;
        chk("pre_rst_ready", req0_ready, 1);
        @(posedge clk);
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, res_valid, res_id, res_lt, res_eq, res_gt}, 6'b0);
        last_g = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (res_valid || busy) n++;
        end
        chk("no_ghost_result", n, 0);
        serve(1, 1, 8'h12, 8'h34, 8'h56, 8'h56, 0);
        // Randomized traffic with occasional equal operands and stalls
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] a0, b0, a1, b1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            a0 = W'($urandom); b0 = ($urandom_range(0, 3) == 0) ? a0 : W'($urandom);
            a1 = W'($urandom); b1 = ($urandom_range(0, 3) == 0) ? a1 : W'($urandom);
            serve(v0, v1, a0, b0, a1, b1, $urandom_range(0, 2));
        end
        // Four-bit instance: 0xA < 0xB after exactly four RUN cycles
        n_req0_valid = 1'b1; n_req0_a = 4'hA; n_req0_b = 4'hB;
        #1;
        chk("w4_ready", n_req0_ready, 1);
        @(posedge clk);
        #1;
        n_req0_valid = 1'b0;
        n = 0;
        while (!n_res_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w4_latency", n, 4);
        chk("w4_flags", {n_res_id, n_res_lt, n_res_eq, n_res_gt}, 4'b0100);
        n_res_ready = 1'b1;
        @(posedge clk);
        #1;
        n_res_ready = 1'b0;
        chk("w4_release", {n_res_valid, n_busy}, 2'b00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_compare_arbiter.md
SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock), rst_n input 1 (asynchronous active-low reset).
REQ-003 The block SHALL have ports req0_valid input 1 (requester 0 has an operand pair), req0_ready output 1 (requester 0 pair accepted this cycle), req0_a input WIDTH, req0_b input WIDTH.
REQ-004 The block SHALL have ports req1_valid input 1, req1_ready output 1, req1_a input WIDTH, req1_b input WIDTH, with the same meanings for requester 1.
REQ-005 The block SHALL have ports res_valid output 1 (result available), res_ready input 1 (consumer takes result), res_id output 1 (requester that owns the result), res_lt output 1 (a<b), res_eq output 1 (a==b), res_gt output 1 (a>b), busy output 1 (state not IDLE).

Function
REQ-006 The block SHALL share one serial one-bit compare stage between two requesters, comparing unsigned operands MSB first, one bit per cycle.
REQ-007 The FSM SHALL have states IDLE, RUN and DONE.
REQ-008 In IDLE, grant: only one valid -> that requester; both valid -> the requester not granted last (round-robin pointer last_grant).
REQ-009 reqN_ready SHALL be high only in IDLE, only for the granted requester, and combinationally only while its reqN_valid is high.
REQ-010 An accept (reqN_valid && reqN_ready at a rising edge) SHALL latch a, b and id=N, set bit index to WIDTH-1, set running flags lt=0, eq=1, gt=0, update last_grant=N, and enter RUN.
REQ-011 Each RUN cycle SHALL process bit[index]: if eq=1 and a bit > b bit then gt=1, eq=0; if eq=1 and a bit < b bit then lt=1, eq=0; if eq=0 flags hold.
REQ-012 After each RUN cycle the index SHALL decrement; the cycle that processes index 0 SHALL transition to DONE.
REQ-013 RUN SHALL always last exactly WIDTH cycles with no early termination, so res_valid rises exactly WIDTH rising edges after the accept edge.
REQ-014 In DONE, res_valid SHALL be 1, and res_id, res_lt, res_eq and res_gt SHALL be held stable until res_valid && res_ready at a rising edge, which returns the FSM to IDLE.
REQ-015 Exactly one of res_lt, res_eq and res_gt SHALL be 1 while res_valid=1; all three and res_id SHALL be 0 while res_valid=0.
REQ-016 No accept SHALL occur in RUN or DONE; minimum spacing between accepts SHALL be WIDTH+2 cycles.
REQ-017 Operand changes on the req ports after the accept edge SHALL NOT affect the in-flight result.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-019 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE with all outputs 0, last_grant=1 (so requester 0 wins the first tie), and operand/flag registers cleared.
REQ-020 A reset asserted during RUN or DONE SHALL discard the in-flight operation; no result for it SHALL ever be presented.
REQ-021 The first accept SHALL be possible at the first rising edge with rst_n=1.

Verification
REQ-022 Stimulus: req0 a=0x5A, b=0x5A, res_ready=1. Required response: req0_ready pulses once; res_valid high 8 edges later with eq=1, lt=0, gt=0, id=0.
REQ-023 Stimulus: req1 a=0x80, b=0x7F. Required response: gt=1 and id=1, with the result after exactly 8 RUN cycles despite the decision at bit 7.
REQ-024 Stimulus: req0 a=0x00, b=0xFF and req1 a=0x01, b=0x00 both valid at the first post-reset edge. Required response: req0 is served first (lt=1, id=0), then req1 (gt=1, id=1); tie on the next request goes to req0.
REQ-025 Stimulus: hold res_ready=0 for 5 cycles in DONE while both requesters are valid. Required response: res_* stable, both reqN_ready=0, busy=1; the result is released on the edge where res_ready=1.
REQ-026 Stimulus: deassert rst_n mid-RUN (4th bit). Required response: outputs go to 0 without waiting for a clock edge and no result appears; after release, a tie grants req0.
REQ-027 Stimulus: WIDTH=4, a=0xA, b=0xB. Required response: lt=1, with res_valid 4 edges after the accept.
